// File: rtl/ov7670_capture_roi.sv
// OV7670 capture front end: byte-pair pixels, ROI crop, decimation, frame-buffer writes.
// Optional CAP_STATS_EN adds frame_cnt and last_line_len outputs.
module ov7670_capture_roi #(
  parameter int H_MAX       = 640,
  parameter int V_MAX       = 480,
  parameter int DEPTH       = 76800,
  parameter int ADDR_W      = 17,
  parameter int SCALE_SHIFT = 0
) (
  input  logic              pclk,
  input  logic              reset_n,
  input  logic              cap_en,
  input  logic              single_shot,
  input  logic [1:0]        fmt_sel,
  input  logic [9:0]        roi_x,
  input  logic [8:0]        roi_y,
  input  logic [9:0]        roi_w,
  input  logic [8:0]        roi_h,
  input  logic              href,
  input  logic              v_sync,
  input  logic [7:0]        ov7670_data,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic [15:0]       wData,
  output logic              busy,
  output logic              frame_done,
  output logic              ovf_err
`ifdef CAP_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [10:0]       last_line_len
`endif
);

  localparam int CW = $clog2(H_MAX) + 1;
  localparam int RW = $clog2(V_MAX) + 1;
  localparam logic [RW-1:0] RMAX = RW'(V_MAX - 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [10:0] SMASK = 11'((1 << SCALE_SHIFT) - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    ACTIVE
  } state_t;

  state_t state, nxt;

  logic          vs_q, vs_d, href_q, href_d;
  logic [7:0]    d_q, b0;
  logic [CW:0]   bcnt;
  logic [RW-1:0] row;
  logic [ADDR_W:0] addr;
  logic [9:0]    rx_l, rw_l;
  logic [8:0]    ry_l, rh_l;
  logic [1:0]    fmt_l;
  logic          ss_l, parked;
  logic          vs_fall, vs_rise, href_fall, start, keep;
  logic [10:0]   col, rowx, x0, x1, y0, y1, dx, dy;
  logic [15:0]   pix;

  assign vs_fall   = vs_d & ~vs_q;
  assign vs_rise   = ~vs_d & vs_q;
  assign href_fall = href_d & ~href_q;
  assign start     = (state == WAIT_FRAME) & cap_en & vs_fall;
  assign busy      = (state != IDLE);

  assign col  = 11'(bcnt[CW:1]);
  assign rowx = 11'(row);
  assign x0   = {1'b0, rx_l};
  assign x1   = x0 + {1'b0, rw_l};
  assign y0   = {2'b0, ry_l};
  assign y1   = y0 + {2'b0, rh_l};
  assign dx   = col - x0;
  assign dy   = rowx - y0;
  assign keep = (col >= x0) & (col < x1) &
                (rowx >= y0) & (rowx < y1) &
                ((dx & SMASK) == '0) &
                ((dy & SMASK) == '0);

  always_comb begin
    pix = {4'h0, b0[7:4], b0[2:0], d_q[7], d_q[4:1]};
    unique case (1'b1)
      fmt_l == 2'd1: pix = {b0, d_q};
      fmt_l == 2'd2: pix = {4'h0, b0[7:4], b0[7:4], b0[7:4]};
      default: ;
    endcase
  end

  // A finished single shot parks in IDLE until cap_en is dropped.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:       if (cap_en && !parked) nxt = WAIT_FRAME;
      WAIT_FRAME: if (!cap_en) nxt = IDLE;
                  else if (vs_fall) nxt = ACTIVE;
      ACTIVE:     if (vs_rise) nxt = (ss_l || !cap_en) ? IDLE : WAIT_FRAME;
      default:    nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q   <= 1'b0;
      vs_d   <= 1'b0;
      href_q <= 1'b0;
      href_d <= 1'b0;
      d_q    <= '0;
      b0     <= '0;
      bcnt   <= '0;
    end else begin
      vs_q   <= v_sync;
      vs_d   <= vs_q;
      href_q <= href;
      href_d <= href_q;
      d_q    <= ov7670_data;
      bcnt   <= href_q ? bcnt + 1'b1 : '0;
      if (href_q && !bcnt[0]) b0 <= d_q;
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      parked     <= 1'b0;
      frame_done <= 1'b0;
      we         <= 1'b0;
      wAddr      <= '0;
      wData      <= '0;
      ovf_err    <= 1'b0;
      addr       <= '0;
      row        <= '0;
      rx_l       <= '0;
      rw_l       <= '0;
      ry_l       <= '0;
      rh_l       <= '0;
      fmt_l      <= '0;
      ss_l       <= 1'b0;
    end else begin
      state      <= nxt;
      frame_done <= (state == ACTIVE) & vs_rise;
      parked     <= cap_en &
                    (parked | ((state == ACTIVE) & vs_rise & ss_l));
      we         <= 1'b0;
      if (start) begin
        rx_l    <= roi_x;
        ry_l    <= roi_y;
        rw_l    <= roi_w;
        rh_l    <= roi_h;
        fmt_l   <= fmt_sel;
        ss_l    <= single_shot;
        addr    <= '0;
        row     <= '0;
        ovf_err <= 1'b0;
      end else if (state == ACTIVE) begin
        if (href_fall && row != RMAX) row <= row + 1'b1;
        if (href_q && bcnt[0] && keep) begin
          if (addr < DEPTH_L) begin
            we    <= 1'b1;
            wAddr <= addr[ADDR_W-1:0];
            wData <= pix;
            addr  <= addr + 1'b1;
          end else begin
            ovf_err <= 1'b1;
          end
        end
      end
    end
  end

`ifdef CAP_STATS_EN
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt     <= '0;
      last_line_len <= '0;
    end else begin
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
      if (href_fall) last_line_len <= 11'(bcnt);
    end
  end
`endif

endmodule

// File: tb/tb_ov7670_capture_roi.sv
// Randomized bench for ov7670_capture_roi: two instances (no decimation, and
// decimation by 2 with a small frame buffer) checked against a frame-level model.
module tb_ov7670_capture_roi;
  localparam int D1 = 50;

  logic pclk = 1'b0;
  logic reset_n = 1'b0;
  logic cap_en = 1'b0;
  logic single_shot = 1'b0;
  logic href = 1'b0;
  logic v_sync = 1'b1;
  logic [1:0] fmt_sel = '0;
  logic [9:0] roi_x = '0;
  logic [9:0] roi_w = '0;
  logic [8:0] roi_y = '0;
  logic [8:0] roi_h = '0;
  logic [7:0] ov7670_data = '0;

  logic we0, busy0, fd0, ovf0;
  logic we1, busy1, fd1, ovf1;
  logic [16:0] wa0, wa1;
  logic [15:0] wd0, wd1;
`ifdef CAP_STATS_EN
  logic [15:0] fc0, fc1;
  logic [10:0] ll0, ll1;
`endif

  ov7670_capture_roi #(.DEPTH(76800), .SCALE_SHIFT(0)) dut0 (
    .pclk(pclk), .reset_n(reset_n), .cap_en(cap_en),
    .single_shot(single_shot), .fmt_sel(fmt_sel),
    .roi_x(roi_x), .roi_y(roi_y), .roi_w(roi_w), .roi_h(roi_h),
    .href(href), .v_sync(v_sync), .ov7670_data(ov7670_data),
    .we(we0), .wAddr(wa0), .wData(wd0), .busy(busy0),
    .frame_done(fd0), .ovf_err(ovf0)
`ifdef CAP_STATS_EN
    , .frame_cnt(fc0), .last_line_len(ll0)
`endif
  );

  ov7670_capture_roi #(.DEPTH(D1), .SCALE_SHIFT(1)) dut1 (
    .pclk(pclk), .reset_n(reset_n), .cap_en(cap_en),
    .single_shot(single_shot), .fmt_sel(fmt_sel),
    .roi_x(roi_x), .roi_y(roi_y), .roi_w(roi_w), .roi_h(roi_h),
    .href(href), .v_sync(v_sync), .ov7670_data(ov7670_data),
    .we(we1), .wAddr(wa1), .wData(wd1), .busy(busy1),
    .frame_done(fd1), .ovf_err(ovf1)
`ifdef CAP_STATS_EN
    , .frame_cnt(fc1), .last_line_len(ll1)
`endif
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  logic [16:0] ga0[$], ga1[$];
  logic [15:0] gd0[$], gd1[$];
  int nfd0 = 0, nfd1 = 0;
  logic [7:0] lb [0:15][0:1023];
  int llen [0:15];
  bit waiting = 0, parked = 0, movf0 = 0, movf1 = 0;
  int fdtot = 0;
  bit force_on = 0;
  logic [7:0] fb0 = '0, fb1 = '0;

  always @(negedge pclk) begin
    if (we0) begin ga0.push_back(wa0); gd0.push_back(wd0); end
    if (we1) begin ga1.push_back(wa1); gd1.push_back(wd1); end
    if (fd0) nfd0++;
    if (fd1) nfd1++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  function automatic logic [15:0] pixel(input int fmt, input logic [7:0] b0,
                                        input logic [7:0] b1);
    logic [4:0] r5, bl5;
    logic [5:0] g6;
    r5 = b0[7:3];
    g6 = {b0[2:0], b1[7:5]};
    bl5 = b1[4:0];
    if (fmt == 1) return {b0, b1};
    if (fmt == 2) return {4'h0, b0[7:4], b0[7:4], b0[7:4]};
    return {4'h0, r5[4:1], g6[5:2], bl5[4:1]};
  endfunction

  task automatic score(input string tg, input int ss, input int depth,
                       input int nl, input bit cap, input bit ovf_prev,
                       input logic [16:0] ga[$], input logic [15:0] gd[$],
                       input int nfd, input logic ovf_now,
                       output bit ovf_out);
    logic [16:0] ea[$];
    logic [15:0] ed[$];
    int a, step, rx, ry, rw, rh, n;
    bit ov;
    a = 0; ov = 0; step = 1 << ss;
    rx = int'(roi_x); ry = int'(roi_y);
    rw = int'(roi_w); rh = int'(roi_h);
    if (cap)
      for (int r = 0; r < nl; r++)
        for (int c = 0; 2 * c + 1 < llen[r]; c++)
          if (c >= rx && c < rx + rw && r >= ry && r < ry + rh &&
              (c - rx) % step == 0 && (r - ry) % step == 0) begin
            if (a < depth) begin
              ea.push_back(17'(a));
              ed.push_back(pixel(int'(fmt_sel), lb[r][2*c], lb[r][2*c+1]));
              a++;
            end else ov = 1;
          end
    check({tg, "_writes"}, ga.size(), ea.size());
    n = (ga.size() < ea.size()) ? ga.size() : ea.size();
    for (int i = 0; i < n; i++) begin
      check({tg, "_addr"}, ga[i], ea[i]);
      check({tg, "_data"}, gd[i], ed[i]);
    end
    check({tg, "_frame_done"}, nfd, cap ? 1 : 0);
    ovf_out = cap ? ov : ovf_prev;
    check({tg, "_ovf"}, ovf_now, ovf_out);
  endtask

  task automatic run_frame(input int nl, input int bpl, input int last_len,
                           input int rst_line, input bit drop_cap);
    bit cap, rst_hit;
    int len;
    logic [7:0] d;
    v_sync = 1'b1;
    repeat (6) tick();
    if (!cap_en) begin waiting = 0; parked = 0; end
    else if (!parked) waiting = 1;
    cap = waiting;
    rst_hit = 0;
    ga0.delete(); gd0.delete(); ga1.delete(); gd1.delete();
    nfd0 = 0; nfd1 = 0;
    v_sync = 1'b0;
    repeat (4) tick();
    if (cap) begin
      check("ovf_clear0", ovf0, 0);
      check("ovf_clear1", ovf1, 0);
    end
    for (int l = 0; l < nl; l++) begin
      len = (l == nl - 1 && last_len > 0) ? last_len : bpl;
      llen[l] = len;
      for (int b = 0; b < len; b++) begin
        d = 8'($urandom);
        if (force_on && l == 0 && b == 0) d = fb0;
        if (force_on && l == 0 && b == 1) d = fb1;
        lb[l][b] = d;
        href = 1'b1;
        ov7670_data = d;
        if (l == rst_line && b == len / 2) begin
          reset_n = 1'b0;
          #1;
          check("rst_we0", we0, 0);
          check("rst_we1", we1, 0);
          check("rst_busy0", busy0, 0);
          check("rst_ovf1", ovf1, 0);
          ga0.delete(); gd0.delete(); ga1.delete(); gd1.delete();
          nfd0 = 0; nfd1 = 0;
          rst_hit = 1;
          movf0 = 0; movf1 = 0; fdtot = 0;
        end
        if (l == rst_line && b == len / 2 + 3) reset_n = 1'b1;
        tick();
      end
      href = 1'b0;
      repeat (5) tick();
    end
    repeat (3) tick();
    v_sync = 1'b1;
    tick();
    if (drop_cap) cap_en = 1'b0;
    repeat (8) tick();
    if (rst_hit) cap = 0;
    score("f0", 0, 76800, nl, cap, movf0, ga0, gd0, nfd0, ovf0, movf0);
    score("f1", 1, D1, nl, cap, movf1, ga1, gd1, nfd1, ovf1, movf1);
    if (rst_hit) begin
      waiting = cap_en; parked = 0;
    end else if (cap) begin
      if (single_shot || !cap_en) waiting = 0;
      if (single_shot && cap_en) parked = 1;
    end
    if (cap_en && !parked) waiting = 1;
    if (cap) fdtot++;
    check("busy0", busy0, waiting);
    check("busy1", busy1, waiting);
`ifdef CAP_STATS_EN
    check("line_len", ll0, llen[nl-1]);
    check("frame_cnt", fc0, fdtot);
`endif
  endtask

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) tick();
    check("rst_we", we0, 0);
    check("rst_waddr", wa0, 0);
    check("rst_wdata", wd0, 0);
    check("rst_busy", busy0, 0);
    check("rst_fd", fd0, 0);
    check("rst_ovf", ovf0, 0);
    check("rst_we_d", we1, 0);
    check("rst_busy_d", busy1, 0);
    reset_n = 1'b1;
    tick();
    check("idle_busy", busy0, 0);

    cap_en = 1'b1;
    fmt_sel = 2'd0;
    roi_x = 0; roi_y = 0; roi_w = 24; roi_h = 12;
    force_on = 1; fb0 = 8'hF7; fb1 = 8'h9E;
    tick(); tick();
    check("arm_busy", busy0, 1);
    run_frame(12, 48, 0, -1, 0);
    check("ovf_full_d", ovf1, 1);
    force_on = 0;

    fmt_sel = 2'd1;
    roi_x = 5; roi_y = 3; roi_w = 10; roi_h = 6;
    run_frame(12, 48, 0, -1, 0);

    fmt_sel = 2'd2;
    roi_x = 0; roi_y = 0; roi_w = 330; roi_h = 3;
    force_on = 1; fb0 = 8'hA5; fb1 = 8'h00;
    run_frame(3, 48, 641, -1, 0);
    check("grey_a5", (gd0.size() > 0) ? 32'(gd0[0]) : 32'hdead, 32'h0AAA);
    check("odd_writes", ga0.size(), 24 + 24 + 320);
    force_on = 0;

    fmt_sel = 2'd3;
    roi_x = 0; roi_y = 0; roi_w = 0; roi_h = 12;
    run_frame(10, 40, 0, -1, 0);
    roi_w = 20; roi_h = 0;
    run_frame(10, 40, 0, -1, 0);

    for (int k = 0; k < 5; k++) begin
      cap_en = 1'b1;
      fmt_sel = 2'($urandom_range(0, 3));
      roi_x = 10'($urandom_range(0, 20));
      roi_w = 10'($urandom_range(0, 30));
      roi_y = 9'($urandom_range(0, 6));
      roi_h = 9'($urandom_range(0, 12));
      run_frame($urandom_range(4, 16), $urandom_range(24, 72), 0, -1, k == 4);
    end

    cap_en = 1'b1;
    single_shot = 1'b1;
    fmt_sel = 2'd0;
    roi_x = 0; roi_y = 0; roi_w = 16; roi_h = 8;
    repeat (3) run_frame(8, 40, 0, -1, 0);
    check("ss_busy", busy0, 0);

    cap_en = 1'b0; waiting = 0; parked = 0;
    repeat (3) tick();
    single_shot = 1'b0;
    cap_en = 1'b1;
    run_frame(8, 40, 0, 2, 0);
    run_frame(8, 40, 0, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
